// File: rtl/cache_repl_policy.sv
// Per-set replacement state (tree PLRU / LFSR random / FIFO) with invalid-first victim select and a post-reset clear sweep.
// State read has 1-cycle latency (with write bypass); VictimWay is combinational from CurrState; Busy blocks state writes.
module cache_repl_policy #(
    parameter int NUMWAYS   = 4,
    parameter int SETLEN    = 9,
    parameter int NUMLINES  = 128,
    parameter int LFSRWIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CacheEn,
    input  logic               FlushStage,
    input  logic [1:0]         Mode,
    input  logic [NUMWAYS-1:0] HitWay,
    input  logic [NUMWAYS-1:0] ValidWay,
    input  logic [SETLEN-1:0]  CacheSetTag,
    input  logic [SETLEN-1:0]  PAdr,
    input  logic               LRUWriteEn,
    input  logic               InvalidateCache,
    output logic [NUMWAYS-1:0] VictimWay,
    output logic               Busy
);

    localparam int WAYW = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;
    localparam int STW  = NUMWAYS - 1;
    localparam int IDXW = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;

    typedef enum logic {IDLE, CLEAR} sweep_t;

    sweep_t              fsm, fsm_nxt;
    logic [IDXW-1:0]     cnt, cnt_nxt;
    logic [1:0]          mode_q;
    logic [LFSRWIDTH-1:0] lfsr;
    logic [8:0]          lfsr_ext;
    logic                fb;
    logic [STW-1:0]      mem [NUMLINES];
    logic [STW-1:0]      curr_state, next_state;
    logic                restart;
    logic                lfsr_mode, fifo_mode;
    logic                wr_en;
    logic [IDXW-1:0]     wr_idx, rd_idx;
    logic [STW-1:0]      wr_dat;
    logic [WAYW-1:0]     plru_enc, fifo_ptr, mode_enc, inv_enc, vic_enc, hit_enc, upd_enc;
    logic                all_valid, hit;
    logic                unused_bits;

    assign Busy      = (fsm == CLEAR);
    assign restart   = InvalidateCache | (Mode != mode_q);
    assign lfsr_mode = (Mode == 2'b01);
    assign fifo_mode = (Mode == 2'b10);
    assign rd_idx    = CacheSetTag[IDXW-1:0];
    assign fifo_ptr  = curr_state[WAYW-1:0];
    assign all_valid = &ValidWay;
    assign hit       = |HitWay;

    // Sweep FSM
    always_comb begin
        fsm_nxt = fsm;
        cnt_nxt = cnt;
        case (fsm)
            IDLE: begin
                if (restart) begin
                    fsm_nxt = CLEAR;
                    cnt_nxt = '0;
                end
            end
            CLEAR: begin
                if (restart) begin
                    cnt_nxt = '0;
                end else if (cnt == IDXW'(NUMLINES - 1)) begin
                    fsm_nxt = IDLE;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                fsm_nxt = CLEAR;
                cnt_nxt = '0;
            end
        endcase
    end

    // Single write port shared by the sweep and normal updates; the sweep always wins.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = PAdr[IDXW-1:0];
        wr_dat = next_state;
        if (Busy) begin
            wr_en  = ~reset;
            wr_idx = cnt;
            wr_dat = '0;
        end else begin
            wr_en = LRUWriteEn & ~FlushStage & ~restart & ~lfsr_mode & ~reset;
        end
    end

    always_comb begin
        lfsr_ext = 9'(lfsr);
        case (LFSRWIDTH)
            3:       fb = lfsr_ext[2] ^ lfsr_ext[0];
            4:       fb = lfsr_ext[3] ^ lfsr_ext[0];
            5:       fb = lfsr_ext[4] ^ lfsr_ext[3] ^ lfsr_ext[2] ^ lfsr_ext[0];
            6:       fb = lfsr_ext[5] ^ lfsr_ext[4] ^ lfsr_ext[2] ^ lfsr_ext[1];
            7:       fb = lfsr_ext[6] ^ lfsr_ext[5] ^ lfsr_ext[3] ^ lfsr_ext[0];
            9:       fb = lfsr_ext[8] ^ lfsr_ext[6] ^ lfsr_ext[5] ^ lfsr_ext[4] ^ lfsr_ext[3] ^ lfsr_ext[2];
            default: fb = lfsr_ext[7] ^ lfsr_ext[5] ^ lfsr_ext[2] ^ lfsr_ext[1];
        endcase
    end

    // Tree walk: node i has children 2i+1 (bit=0) and 2i+2 (bit=1).
    always_comb begin
        int node;
        node     = 0;
        plru_enc = '0;
        for (int l = 0; l < WAYW; l++) begin
            plru_enc[WAYW-1-l] = curr_state[node];
            node = 2 * node + 1 + (curr_state[node] ? 1 : 0);
        end
    end

    always_comb begin
        inv_enc = '0;
        for (int i = NUMWAYS - 1; i >= 0; i--) begin
            if (!ValidWay[i]) inv_enc = WAYW'(i);
        end
        hit_enc = '0;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (HitWay[i]) hit_enc = WAYW'(i);
        end
    end

    always_comb begin
        case (Mode)
            2'b01:   mode_enc = lfsr[WAYW-1:0];
            2'b10:   mode_enc = fifo_ptr;
            default: mode_enc = plru_enc;
        endcase
        vic_enc            = all_valid ? mode_enc : inv_enc;
        VictimWay          = '0;
        VictimWay[vic_enc] = 1'b1;
        upd_enc            = hit ? hit_enc : vic_enc;
    end

    // Path nodes are flipped to point away from the way just used.
    always_comb begin
        int node;
        node       = 0;
        next_state = curr_state;
        if (fifo_mode) begin
            if (!hit) next_state[WAYW-1:0] = fifo_ptr + 1'b1;
        end else if (!lfsr_mode) begin
            for (int l = 0; l < WAYW; l++) begin
                next_state[node] = ~upd_enc[WAYW-1-l];
                node = 2 * node + 1 + (upd_enc[WAYW-1-l] ? 1 : 0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= CLEAR;
            cnt        <= '0;
            mode_q     <= 2'b00;
            lfsr       <= LFSRWIDTH'(1);
            curr_state <= '0;
        end else begin
            fsm    <= fsm_nxt;
            cnt    <= cnt_nxt;
            mode_q <= Mode;
            if (CacheEn) begin
                lfsr       <= {fb, lfsr[LFSRWIDTH-1:1]};
                curr_state <= (wr_en && (rd_idx == wr_idx)) ? wr_dat : mem[rd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_dat;
    end

    assign unused_bits = ^{CacheSetTag, PAdr, lfsr_ext};

endmodule

// File: tb/tb_cache_repl_policy.sv
// Directed bench for cache_repl_policy: 4-way, 128 sets, 4-bit LFSR.
module tb_cache_repl_policy;

    logic       clk = 1'b0;
    logic       reset;
    logic       CacheEn;
    logic       FlushStage;
    logic [1:0] Mode;
    logic [3:0] HitWay;
    logic [3:0] ValidWay;
    logic [8:0] CacheSetTag;
    logic [8:0] PAdr;
    logic       LRUWriteEn;
    logic       InvalidateCache;
    logic [3:0] VictimWay;
    logic       Busy;

    int checks   = 0;
    int failures = 0;
    int n;
    logic [3:0] exp_lfsr [4] = '{4'b0001, 4'b0001, 4'b0100, 4'b1000};

    cache_repl_policy #(
        .NUMWAYS  (4),
        .SETLEN   (9),
        .NUMLINES (128),
        .LFSRWIDTH(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .CacheEn        (CacheEn),
        .FlushStage     (FlushStage),
        .Mode           (Mode),
        .HitWay         (HitWay),
        .ValidWay       (ValidWay),
        .CacheSetTag    (CacheSetTag),
        .PAdr           (PAdr),
        .LRUWriteEn     (LRUWriteEn),
        .InvalidateCache(InvalidateCache),
        .VictimWay      (VictimWay),
        .Busy           (Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges until Busy drops, sampled 1ns after each rising edge; 400 means it never dropped.
    task automatic count_edges(output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!Busy) break;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; CacheEn = 1'b0; FlushStage = 1'b0; Mode = 2'b00;
        HitWay = '0; ValidWay = '0; CacheSetTag = '0; PAdr = '0;
        LRUWriteEn = 1'b0; InvalidateCache = 1'b0;

        #12;
        check("reset_busy", Busy, 1);
        check("reset_victim", VictimWay, 4'b0001);
        @(negedge clk);
        reset = 1'b0;
        count_edges(n);
        check("sweep_after_reset_len", n, 128);

        // Switch to LFSR with CacheEn low so the LFSR stays at 0001.
        Mode = 2'b01;
        step();
        check("lfsr_mode_busy", Busy, 1);
        count_edges(n);
        check("lfsr_mode_sweep_len", n, 128);
        ValidWay = 4'b1111;
        #1;
        check("lfsr_victim_start", VictimWay, 4'b0010);
        ValidWay = 4'b1011;
        #1;
        check("lfsr_invalid_first", VictimWay, 4'b0100);
        ValidWay = 4'b1111;
        CacheEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("lfsr_victim_%0d", i + 1), VictimWay, exp_lfsr[i]);
        end
        CacheEn = 1'b0;

        Mode = 2'b00;
        step();
        count_edges(n);
        check("plru_mode_sweep_len", n, 128);
        CacheEn = 1'b1;
        CacheSetTag = 9'd127;
        step();
        check("read_set127_cleared", VictimWay, 4'b0001);
        ValidWay = 4'b1011;
        #1;
        check("plru_invalid_first", VictimWay, 4'b0100);
        ValidWay = 4'b1111;

        CacheSetTag = 9'd5;
        PAdr = 9'd5;
        step();
        check("plru_initial", VictimWay, 4'b0001);
        HitWay = 4'b0001; LRUWriteEn = 1'b1;
        step();
        check("plru_after_hit0", VictimWay, 4'b0100);
        HitWay = 4'b0100; FlushStage = 1'b1;
        step();
        check("plru_flush_no_write", VictimWay, 4'b0100);
        FlushStage = 1'b0;
        step();
        check("plru_after_hit2", VictimWay, 4'b0010);
        HitWay = 4'b0010;
        step();
        check("plru_after_hit1", VictimWay, 4'b1000);

        // Mode change with fills still requested: the sweep must drop them.
        HitWay = 4'b0000;
        Mode = 2'b10;
        step();
        check("fifo_mode_busy", Busy, 1);
        count_edges(n);
        check("fifo_mode_sweep_len", n, 128);
        check("fifo_fill1", VictimWay, 4'b0001);
        step();
        check("fifo_fill2", VictimWay, 4'b0010);
        step();
        check("fifo_fill3", VictimWay, 4'b0100);
        HitWay = 4'b1000;
        step();
        check("fifo_hit_keeps_ptr", VictimWay, 4'b0100);
        HitWay = 4'b0000;
        step();
        check("fifo_fill4", VictimWay, 4'b1000);
        step();
        check("fifo_fill5_wrap", VictimWay, 4'b0001);
        LRUWriteEn = 1'b0;
        ValidWay = 4'b1011;
        #1;
        check("fifo_invalid_first", VictimWay, 4'b0100);
        ValidWay = 4'b1111;
        LRUWriteEn = 1'b1;
        step();
        check("fifo_ptr_advanced", VictimWay, 4'b0010);
        LRUWriteEn = 1'b0;

        InvalidateCache = 1'b1;
        step();
        InvalidateCache = 1'b0;
        check("invalidate_busy", Busy, 1);
        repeat (50) @(posedge clk);
        #1;
        check("busy_at_cycle50", Busy, 1);
        InvalidateCache = 1'b1;
        step();
        InvalidateCache = 1'b0;
        count_edges(n);
        check("invalidate_restart_len", n, 128);
        check("set5_cleared", VictimWay, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
